// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with valid/ready handshake,
// synchronous flush and an optional two-entry skid buffer.
module ex_mem_pipe_reg #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int SKID   = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              is_write_in,
   input  logic              is_load_in,
   input  logic              is_store_in,
   input  logic [DATA_W-1:0] alu_result_in,
   input  logic [REG_W-1:0]  register_d_in,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              is_write_out,
   output logic              is_load_out,
   output logic              is_store_out,
   output logic [DATA_W-1:0] alu_result_out,
   output logic [REG_W-1:0]  register_d_out,
   output logic [1:0]        occupancy
);

   typedef struct packed {
      logic              wr;
      logic              ld;
      logic              st;
      logic [DATA_W-1:0] res;
      logic [REG_W-1:0]  rd;
   } beat_t;

   typedef enum logic [1:0] {
      EMPTY,
      ONE,
      FULL
   } state_t;

   state_t state;
   beat_t  beat_in;
   beat_t  m_q;
   beat_t  s_q;
   logic   m_valid;
   logic   s_valid;
   logic   accept;
   logic   drain;

   assign beat_in = '{
      wr:  is_write_in,
      ld:  is_load_in,
      st:  is_store_in,
      res: alu_result_in,
      rd:  register_d_in
   };

   // With the skid entry, in_ready depends only on registered state,
   // so out_ready never reaches the EX stage combinationally.
   generate
      if (SKID != 0) begin : g_skid
         assign in_ready = !s_valid;
      end else begin : g_noskid
         assign in_ready = !m_valid | out_ready;
      end
   endgenerate

   assign accept = in_valid & in_ready;
   assign drain  = m_valid & out_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= EMPTY;
         m_q     <= '0;
         s_q     <= '0;
         m_valid <= 1'b0;
         s_valid <= 1'b0;
      end else if (flush) begin
         state   <= EMPTY;
         m_valid <= 1'b0;
         s_valid <= 1'b0;
      end else begin
         unique case (state)
            EMPTY: begin
               if (accept) begin
                  m_q     <= beat_in;
                  m_valid <= 1'b1;
                  state   <= ONE;
               end
            end
            ONE: begin
               if (accept && drain) begin
                  m_q <= beat_in;
               end else if (accept && SKID != 0) begin
                  // M is stalled: the newer beat waits behind it in S
                  s_q     <= beat_in;
                  s_valid <= 1'b1;
                  state   <= FULL;
               end else if (drain) begin
                  m_valid <= 1'b0;
                  state   <= EMPTY;
               end
            end
            FULL: begin
               if (drain) begin
                  m_q     <= s_q;
                  s_valid <= 1'b0;
                  state   <= ONE;
               end
            end
            default: begin
               state   <= EMPTY;
               m_valid <= 1'b0;
               s_valid <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid      = m_valid;
   assign is_write_out   = m_q.wr & m_valid;
   assign is_load_out    = m_q.ld & m_valid;
   assign is_store_out   = m_q.st & m_valid;
   assign alu_result_out = m_q.res;
   assign register_d_out = m_q.rd;
   assign occupancy      = {1'b0, m_valid} + {1'b0, s_valid};

endmodule

// File: doc/ex_mem_pipe_reg.md
# ex_mem_pipe_reg

Parametrised EX→MEM pipeline register for the multi-cycle/pipelined core. It supersedes the fixed 32-bit ALU result latch with three additions:
- a valid/ready handshake in both directions;
- a synchronous flush for branch squash;
- an optional two-entry skid buffer, so back-pressure from the memory stage never drops an ALU result.

It sits between the ALU output and the data-memory/write-back stage.

## Interface

Parameters:
- DATA_W, 32, width of the ALU result / store data path
- REG_W, 5, width of the destination register index
- SKID, 1, 1 = two-entry buffer with registered in_ready; 0 = single entry with combinational in_ready

Ports:
- clk  in  1  rising-edge clock (single clock domain)
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  EX stage presents a beat
- in_ready  out  1  stage can accept a beat this cycle
- is_write_in / is_load_in / is_store_in  in  1 each  control bits of the beat
- alu_result_in  in  DATA_W  ALU result / memory address
- register_d_in  in  REG_W  destination register index
- flush  in  1  synchronous squash of all held and incoming beats
- out_valid  out  1  MEM stage is presented a beat
- out_ready  in  1  MEM stage consumes the beat
- is_write_out / is_load_out / is_store_out  out  1 each  control bits, forced 0 when out_valid=0
- alu_result_out  out  DATA_W  held result
- register_d_out  out  REG_W  held destination index
- occupancy  out  2  number of held beats, 0..2 (0..1 when SKID=0)

## Operation

- Storage:
  - Main entry M, which drives the outputs.
  - Skid entry S (present only when SKID=1).
  - Each entry holds {write, load, store, result, rd} plus a valid bit.
- Accept: a beat transfers when in_valid & in_ready. Drain: a beat leaves when out_valid & out_ready.
- out_valid = M.valid. The control outputs are ANDed with M.valid, so a bubble never writes or stores.
- Registered in_ready for SKID=1:
  - in_ready = !S.valid.
  - occupancy = M.valid + S.valid.
- SKID=1 state machine (states EMPTY, ONE, FULL):
  - EMPTY: accept → ONE (beat into M).
  - ONE:
    - accept & drain → ONE (new beat into M).
    - accept & !drain → FULL (new beat into S).
    - drain & !accept → EMPTY.
  - FULL (in_ready=0):
    - drain → ONE (S moves to M, S cleared).
    - otherwise hold.
- Combinational in_ready for SKID=0:
  - in_ready = !M.valid | out_ready.
  - Behaves as a stallable pipeline register with states EMPTY/ONE only.
- Ordering: beats leave strictly in acceptance order. S is never overtaken by a newer beat.
- Flush:
  - At the next edge, M.valid and S.valid clear → EMPTY.
  - A beat accepted in the same cycle is discarded.
  - flush takes priority over accept and drain.
  - Data fields may hold stale values; only the valid bits and gated control outputs matter.
- Hold: data fields of an entry change only when that entry is loaded.

## Timing

- Reset (reset_n low, asynchronous, takes effect immediately, no clock needed):
  - M.valid, S.valid, all control outputs, alu_result_out, register_d_out and occupancy go to 0.
  - in_ready = 1.
- Reset deasserts synchronously to the design. The first accept is possible on the first rising edge with reset_n high.
- Latency: one clock from accept to out_valid.
- Throughput: one beat per clock while out_ready=1.
- With SKID=1, in_ready has no combinational path from out_ready.
- Reset asserted mid-operation (FULL, with outputs held): all beats are lost and outputs zero at once. No partial state survives.
- Simultaneous events:
  - FULL with drain: S→M and in_ready rises next cycle. No input is accepted that cycle because in_ready=0.
  - ONE with accept & drain: the new beat lands in M and occupancy stays 1.

## Test plan

- Reset: drive reset_n=0 while FULL with result 0xDEADBEEF → all outputs 0, in_ready=1 within the same cycle, occupancy=0.
- Streaming: out_ready=1, SKID=1, accept results 1,2,3,4 on consecutive clocks (rd=5'd1..4) → out_valid from the cycle after the first accept, outputs 1,2,3,4 in order on consecutive cycles, occupancy never exceeds 1.
- Back-pressure: out_ready=0, send 0xA then 0xB:
  - occupancy=2 and in_ready=0.
  - Raise out_ready → 0xA then 0xB appear in order, in_ready=1 the cycle after 0xA drains.
  - A third beat 0xC held on in_valid during FULL is not accepted until in_ready=1.
- Flush: FULL (0xA, 0xB), then assert flush with in_valid=1 (0xC) → next cycle out_valid=0, is_store_out=0, occupancy=0, and 0xC never appears.
- Bubble gating: in_valid=0 with is_store_in=1 and is_write_in=1 → out_valid=0, is_store_out=0, is_write_out=0.
- SKID=0, DATA_W=64, REG_W=6: with M full and out_ready=0, in_ready=0. Raise out_ready with in_valid=1 → replacement in the same cycle, 64-bit value 0x0123456789ABCDEF and rd=6'd40 appear next cycle.
